// File: rtl/hash_accel_pkg.sv
// hash_accel_pkg
// Shared definitions for the hash accelerator bus controller:
//   - FSM state encoding (also reported in the LEN status word)
//   - bus address window codes (bus_addr[31:28])
//   - default buffer geometry
//   - small helpers for length clamping and status-word packing
package hash_accel_pkg;

  localparam int DEF_DATA_DEPTH = 256;
  localparam int DEF_HASH_BYTES = 32;

  localparam logic [3:0] WIN_LEN  = 4'h1;
  localparam logic [3:0] WIN_DATA = 4'h2;
  localparam logic [3:0] WIN_HASH = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Requested message length saturated to the message buffer depth.
  function automatic logic [31:0] clamp_len(input logic [31:0] req_len,
                                            input logic [31:0] depth);
    return (req_len > depth) ? depth : req_len;
  endfunction

  // LEN window read-back: {state, 13'b0, len[15:0]}.
  function automatic logic [31:0] status_word(input logic [2:0]  st,
                                              input logic [15:0] len_lo);
    return {st, 13'd0, len_lo};
  endfunction

endpackage

// File: rtl/hash_accel_dpram.sv
// hash_accel_dpram
// Generic single-write / single-read byte RAM with a registered read port,
// matching the 1-cycle latency the HLS core expects from a BRAM.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset (read register only)
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i/rdata_o   read port, rdata_o updates the cycle after re_i
// Storage contents are not reset.
module hash_accel_dpram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port: storage array, no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_r[waddr_i] <= wdata_i;
    end
  end

  // Read port: registered output, cleared by reset, held when not enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= {WIDTH{1'b0}};
    end else if (re_i) begin
      rdata_o <= mem_r[raddr_i];
    end
  end

endmodule

// File: rtl/hash_accel_ctrl.sv
// hash_accel_ctrl
// UDM-bus-side sequencer for the hash accelerator core. Accepts a length,
// collects that many message bytes, starts the core (ap_ctrl_hs), and then
// serves the digest back one byte per HASH-window read.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   bus_*                        UDM bus: req/we/addr/be/wdata in, ack/resp/rdata out
//   len_o                        clamped message length for the core
//   ap_start_o, ap_done_i, ap_idle_i, ap_ready_i   core handshake
//   data_address0_i/ce0_i/q0_o   core read port into the message buffer
//   hash_*0_i, hash_*1_i         core write ports into the digest buffer
//   busy_o                       high while in START or RUN
module hash_accel_ctrl
  import hash_accel_pkg::*;
#(
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int HASH_BYTES = DEF_HASH_BYTES,
  parameter int AW         = $clog2(DATA_DEPTH),
  parameter int HW         = $clog2(HASH_BYTES)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          bus_req_i,
  input  logic          bus_we_i,
  input  logic [31:0]   bus_addr_i,
  input  logic [3:0]    bus_be_i,
  input  logic [31:0]   bus_wdata_i,
  output logic          bus_ack_o,
  output logic          bus_resp_o,
  output logic [31:0]   bus_rdata_o,
  output logic [31:0]   len_o,
  output logic          ap_start_o,
  input  logic          ap_done_i,
  input  logic          ap_idle_i,
  input  logic          ap_ready_i,
  input  logic [AW-1:0] data_address0_i,
  input  logic          data_ce0_i,
  output logic [7:0]    data_q0_o,
  input  logic [HW-1:0] hash_address0_i,
  input  logic [HW-1:0] hash_address1_i,
  input  logic          hash_ce0_i,
  input  logic          hash_ce1_i,
  input  logic          hash_we0_i,
  input  logic          hash_we1_i,
  input  logic [7:0]    hash_d0_i,
  input  logic [7:0]    hash_d1_i,
  output logic          busy_o
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_START = ST_START;
  localparam logic [2:0] S_RUN   = ST_RUN;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0]    state_r;
  logic [2:0]    state_nx_s;
  logic [31:0]   len_r;
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   wr_ptr_inc_s;
  logic [HW-1:0] rd_ptr_r;
  logic          ap_start_r;
  logic          busy_r;
  logic          resp_r;
  logic [31:0]   rdata_r;
  logic [31:0]   rdata_nx_s;
  logic [7:0]    hash_mem_r [HASH_BYTES];

  logic [3:0]    win_s;
  logic          wr_s;
  logic          rd_s;
  logic          len_wr_s;
  logic          data_wr_s;
  logic          hash_rd_s;
  logic [31:0]   clamp_s;
  logic          load_last_s;

  // Inputs with no functional role here; kept for interface completeness.
  logic          unused_ok_s;
  assign unused_ok_s = &{1'b0, bus_be_i, bus_addr_i[27:0], ap_idle_i, ap_ready_i};

  // The block never stalls, so every request is accepted immediately.
  assign bus_ack_o = bus_req_i;

  assign win_s        = bus_addr_i[31:28];
  assign wr_s         = bus_req_i & bus_we_i;
  assign rd_s         = bus_req_i & ~bus_we_i;
  assign clamp_s      = clamp_len(bus_wdata_i, 32'(DATA_DEPTH));
  assign wr_ptr_inc_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
  assign load_last_s  = (32'(wr_ptr_inc_s) == len_r);

  // LEN writes restart a transfer only while the core is not running.
  assign len_wr_s  = wr_s && (win_s == WIN_LEN) &&
                     ((state_r == S_IDLE) || (state_r == S_LOAD) || (state_r == S_DONE));
  assign data_wr_s = wr_s && (win_s == WIN_DATA) && (state_r == S_LOAD);
  // Digest pops only once the core has finished; otherwise the read yields 0.
  assign hash_rd_s = rd_s && (win_s == WIN_HASH) && (state_r == S_DONE);

  // Next-state logic for the transfer sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (len_wr_s) begin
          state_nx_s = (clamp_s == 32'd0) ? S_START : S_LOAD;
        end else begin
          state_nx_s = state_r;
        end
      end
      S_LOAD: begin
        if (len_wr_s) begin
          state_nx_s = (clamp_s == 32'd0) ? S_START : S_LOAD;
        end else if (data_wr_s && load_last_s) begin
          state_nx_s = S_START;
        end else begin
          state_nx_s = S_LOAD;
        end
      end
      S_START: begin
        state_nx_s = S_RUN;
      end
      S_RUN: begin
        if (ap_done_i) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_RUN;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // State, length, pointers, and the start/busy outputs (registered from next state
  // so ap_start drops in the same cycle the FSM enters DONE).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= S_IDLE;
      len_r      <= 32'd0;
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {HW{1'b0}};
      ap_start_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      ap_start_r <= (state_nx_s == S_START) || (state_nx_s == S_RUN);
      busy_r     <= (state_nx_s == S_START) || (state_nx_s == S_RUN);
      if (len_wr_s) begin
        len_r    <= clamp_s;
        wr_ptr_r <= {(AW+1){1'b0}};
        rd_ptr_r <= {HW{1'b0}};
      end else begin
        if (data_wr_s) begin
          wr_ptr_r <= wr_ptr_inc_s;
        end
        if (hash_rd_s) begin
          rd_ptr_r <= rd_ptr_r + HW'(1);
        end
      end
    end
  end

  // Digest register file: two core write ports, port 1 written last so it wins a collision.
  always_ff @(posedge clk_i) begin
    if (hash_ce0_i && hash_we0_i) begin
      hash_mem_r[hash_address0_i] <= hash_d0_i;
    end
    if (hash_ce1_i && hash_we1_i) begin
      hash_mem_r[hash_address1_i] <= hash_d1_i;
    end
  end

  // Read-data selection by address window.
  always_comb begin
    rdata_nx_s = 32'd0;
    if (rd_s) begin
      case (win_s)
        WIN_LEN: begin
          rdata_nx_s = status_word(state_r, len_r[15:0]);
        end
        WIN_HASH: begin
          if (hash_rd_s) begin
            rdata_nx_s = {24'd0, hash_mem_r[rd_ptr_r]};
          end else begin
            rdata_nx_s = 32'd0;
          end
        end
        default: begin
          rdata_nx_s = 32'd0;
        end
      endcase
    end else begin
      rdata_nx_s = 32'd0;
    end
  end

  // Registered read response: single-cycle resp pulse one cycle after the request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_r  <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      resp_r  <= rd_s;
      rdata_r <= rdata_nx_s;
    end
  end

  hash_accel_dpram #(
    .DEPTH (DATA_DEPTH),
    .WIDTH (8),
    .AW    (AW)
  ) u_msg_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (data_wr_s),
    .waddr_i (wr_ptr_r[AW-1:0]),
    .wdata_i (bus_wdata_i[7:0]),
    .re_i    (data_ce0_i),
    .raddr_i (data_address0_i),
    .rdata_o (data_q0_o)
  );

  assign bus_resp_o  = resp_r;
  assign bus_rdata_o = rdata_r;
  assign len_o       = len_r;
  assign ap_start_o  = ap_start_r;
  assign busy_o      = busy_r;

endmodule
